fpu_8097_stack_ctl: RTL and testbench
=====================================

Name: fpu_8097_stack_ctl

Overview:
Parametrised x87-style register-stack controller for the 8097 FPU.
- Holds DEPTH entries of WIDTH bits, a TOP pointer and a per-entry tag word.
- Detects stack overflow and underflow, and assembles the stack-related bits of the x87 status word.
- Sits between the CSR command decoder and the arithmetic datapath. Each accepted operation returns one response through a single-entry valid/ready response register.

Parameters:
- DEPTH, 8, number of stack entries; power of two, 2..16.
- WIDTH, 80, entry width in bits.
- TOPW, $clog2(DEPTH), TOP pointer width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- op_valid  in  1  operation request
- op_ready  out  1  controller can accept an operation
- op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 READ, 4 WRITE, 5 EXCH, 6 FREE, 7 illegal
- op_idx  in  TOPW  stack-relative index i, meaning ST(i)
- op_wdata  in  WIDTH  data for PUSH and WRITE
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  WIDTH  read data
- rsp_fault  out  8  fault code; 0x00 none, 0x10 underflow, 0x11 overflow, 0x12 illegal command
- sw_clr  in  1  clear sticky status flags
- sw  out  16  status word
- top  out  TOPW  current TOP
- tag  out  DEPTH  tag bit per physical entry; 1 = valid, 0 = empty

Behaviour:
- Reset values: top=0, tag=0, sticky flags=0, rsp_valid=0, rsp_data=0, rsp_fault=0. Storage array is not reset.
- Reset mid-operation discards any pending response.
- Handshake:
  - op_ready = !rsp_valid || rsp_ready.
  - An operation is accepted on op_valid && op_ready.
  - rsp_valid rises the cycle after acceptance. rsp_data and rsp_fault are held stable until rsp_ready.
  - Full throughput: back-to-back acceptance is allowed while rsp_ready=1.
- Addressing: phys(i) = (top + i) mod DEPTH. Wrap-around is implicit in the TOPW-bit arithmetic.
- NOP: no state change; fault 0x00.
- PUSH:
  - nt = top-1 mod DEPTH.
  - If tag[nt]=1: overflow, fault 0x11, no state change.
  - Otherwise: mem[nt] = op_wdata, tag[nt] = 1, top = nt.
- POP:
  - If tag[top]=0: underflow, fault 0x10, no state change.
  - Otherwise: rsp_data = mem[top], tag[top] = 0, top = top+1.
- READ: if tag[phys(i)]=0, underflow; otherwise rsp_data = mem[phys(i)].
- WRITE: mem[phys(i)] = op_wdata, tag set; never faults.
- EXCH:
  - If ST(0) or ST(i) is empty: underflow, no change.
  - Otherwise swap the two entries; rsp_data = old ST(0).
  - i=0 is legal and is a no-op that returns ST(0).
- FREE: tag[phys(i)] = 0; never faults.
- Illegal opcode 7: fault 0x12, no state change, sw unchanged.
- On any non-faulting op: rsp_fault = 0x00. rsp_data = 0 for PUSH, WRITE, FREE and NOP.
- On a faulting op: rsp_data = 0.
- Status word (sticky flags are cleared only by sw_clr or reset):
  - Bit 0 IE and bit 6 SF: set on overflow or underflow.
  - Bit 7 ES = IE.
  - Bit 9 C1: set to 1 on overflow, 0 on underflow.
  - Bits 13:11 = top[2:0]. Zero-extended when TOPW<3; low 3 bits only when DEPTH=16.
  - Bits 2, 3, 4, 5, 8, 10, 14, 15 are always 0 (owned by the arithmetic unit).
- sw_clr clears IE, SF, ES and C1 at the next edge. If a stack fault is recorded in the same cycle, the set wins.

Optional Feature:
FPU8097_STK_MASKED_INDEF_EN
- Defined:
  - Overflow PUSH still performs top = nt and writes the indefinite value (all ones) to mem[nt], tag=1.
  - Underflow READ or POP returns all ones in rsp_data; POP still increments top and clears the tag.
  - Fault codes and flags are unchanged from the base behaviour.
- Undefined: base behaviour above, with no state change on a fault.

Test Plan:
1. Reset, then PUSH 0x1 -> top=7, tag=0x80, sw=0x3800, rsp_fault=0x00.
2. Eight PUSHes of values 1..8 -> top=0, tag=0xFF. A ninth PUSH -> rsp_fault=0x11, sw=0x02C1, top=0, tag=0xFF.
3. POP after reset -> rsp_fault=0x10, sw=0x00C1, top=0. Then sw_clr -> sw=0x0000.
4. PUSH A=0x5, PUSH B=0x9:
   - READ idx1 -> 0x5.
   - EXCH idx1 -> rsp_data=0x9.
   - READ idx0 -> 0x5.
   - POP twice -> 0x5 then 0x9; top=0, tag=0x00.
5. rsp_ready held low for 3 cycles with op_valid=1 -> op_ready=0 and exactly one acceptance. Once rsp_ready=1, the next op is accepted in the same cycle.
6. Opcode 7 -> rsp_fault=0x12 and sw unchanged. sw_clr coincident with an underflow POP -> sw=0x00C1.

Source files
------------

// File: rtl/fpu_8097_stack_ctl.sv
// fpu_8097_stack_ctl: x87-style register-stack controller for the 8097 FPU.
// Holds DEPTH entries of WIDTH bits with a TOP pointer and per-entry tags,
// detects stack overflow/underflow and assembles the stack bits of the status word.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   op_valid/op_ready             operation handshake
//   op_code, op_idx, op_wdata     operation, ST(i) index, write data
//   rsp_valid/rsp_ready           single-entry response handshake
//   rsp_data, rsp_fault           response data and fault code
//   sw_clr, sw                    sticky flag clear, status word
//   top, tag                      current TOP, per-physical-entry valid tags
// Optional feature: define FPU8097_STK_MASKED_INDEF_EN for masked-response
// behaviour (faulting PUSH/POP/READ still act, producing the indefinite value).
module fpu_8097_stack_ctl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 80,
    localparam int TOPW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [TOPW-1:0]  op_idx,
    input  logic [WIDTH-1:0] op_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [7:0]       rsp_fault,
    input  logic             sw_clr,
    output logic [15:0]      sw,
    output logic [TOPW-1:0]  top,
    output logic [DEPTH-1:0] tag
);
`ifdef FPU8097_STK_MASKED_INDEF_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif
    localparam logic [7:0] F_UNF = 8'h10;
    localparam logic [7:0] F_OVF = 8'h11;
    localparam logic [7:0] F_ILL = 8'h12;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [TOPW-1:0]  nt, p, wa, top_n;
    logic [DEPTH-1:0] tag_n;
    logic [WIDTH-1:0] wd, data;
    logic [7:0]       flt;
    logic             we, xch, acc, stk, ie, c1;
    logic [2:0]       top3;

    assign op_ready = !rsp_valid || rsp_ready;
    assign acc      = op_valid && op_ready;
    assign nt       = top - 1'b1;
    assign p        = top + op_idx;
    assign stk      = acc && (flt == F_UNF || flt == F_OVF);
    // TOP field is 3 bits wide regardless of DEPTH: zero-extend or truncate
    assign top3     = 3'(top);
    // IE, SF and ES always move together, so one sticky bit serves all three
    assign sw       = {2'b00, top3, 1'b0, c1, 1'b0, ie, ie, 5'b00000, ie};

    always_comb begin
        flt   = 8'h00;
        data  = '0;
        top_n = top;
        tag_n = tag;
        we    = 1'b0;
        wa    = p;
        wd    = op_wdata;
        xch   = 1'b0;
        case (op_code)
            3'd1: begin
                flt = tag[nt] ? F_OVF : 8'h00;
                if (!tag[nt] || MASKED) begin
                    we        = 1'b1;
                    wa        = nt;
                    wd        = tag[nt] ? {WIDTH{1'b1}} : op_wdata;
                    top_n     = nt;
                    tag_n[nt] = 1'b1;
                end
            end
            3'd2: begin
                flt  = tag[top] ? 8'h00 : F_UNF;
                data = tag[top] ? mem[top] : {WIDTH{MASKED}};
                if (tag[top] || MASKED) begin
                    top_n      = top + 1'b1;
                    tag_n[top] = 1'b0;
                end
            end
            3'd3: begin
                flt  = tag[p] ? 8'h00 : F_UNF;
                data = tag[p] ? mem[p] : {WIDTH{MASKED}};
            end
            3'd4: begin
                we       = 1'b1;
                tag_n[p] = 1'b1;
            end
            3'd5: begin
                xch  = tag[top] && tag[p];
                flt  = xch ? 8'h00 : F_UNF;
                data = xch ? mem[top] : '0;
            end
            3'd6: tag_n[p] = 1'b0;
            3'd7: flt = F_ILL;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc && we) mem[wa] <= wd;
        if (acc && xch) begin
            mem[top] <= mem[p];
            mem[p]   <= mem[top];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top       <= '0;
            tag       <= '0;
            ie        <= 1'b0;
            c1        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_fault <= 8'h00;
        end else begin
            if (acc) begin
                top       <= top_n;
                tag       <= tag_n;
                rsp_data  <= data;
                rsp_fault <= flt;
            end
            rsp_valid <= acc || (rsp_valid && !rsp_ready);
            // a fault recorded this cycle overrides a coincident clear
            ie        <= stk || (ie && !sw_clr);
            c1        <= stk ? (flt == F_OVF) : (c1 && !sw_clr);
        end
    end
endmodule

// File: tb/tb_fpu_8097_stack_ctl.sv
// tb_fpu_8097_stack_ctl: directed self-checking bench with a behavioural stack model.
module tb_fpu_8097_stack_ctl;
`ifdef FPU8097_STK_MASKED_INDEF_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif
    localparam int D = 8;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, READ = 3'd3,
                           WRITE = 3'd4, EXCH = 3'd5, FREE = 3'd6, ILL = 3'd7;

    logic        clk, rst, op_valid, op_ready, rsp_valid, rsp_ready, sw_clr;
    logic [2:0]  op_code, op_idx, top;
    logic [79:0] op_wdata, rsp_data;
    logic [7:0]  rsp_fault, tag;
    logic [15:0] sw;

    int vectors = 0;
    int miscompares = 0;
    int d_acc = 0;

    logic [79:0] m_mem [D];
    bit          m_tag [D];
    int          m_top;
    bit          m_ie, m_c1, m_rv;
    logic [79:0] m_rd;
    logic [7:0]  m_rf;

    fpu_8097_stack_ctl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_idx(op_idx), .op_wdata(op_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_fault(rsp_fault), .sw_clr(sw_clr), .sw(sw), .top(top), .tag(tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [7:0] m_tagv();
        logic [7:0] v;
        for (int i = 0; i < D; i++) v[i] = m_tag[i];
        return v;
    endfunction

    function automatic logic [15:0] m_sw();
        return 16'((m_top % 8) << 11) | (m_ie ? 16'h00C1 : 16'h0000) | (m_c1 ? 16'h0200 : 16'h0000);
    endfunction

    always @(posedge clk) if (op_valid && op_ready) d_acc++;

    // behavioural model: stack of D slots addressed relative to TOP
    always @(posedge clk or posedge rst) begin : model
        int p, nt;
        bit acc, stk, ovf;
        logic [79:0] tmp;
        if (rst) begin
            m_top = 0;
            for (int i = 0; i < D; i++) m_tag[i] = 1'b0;
            m_ie = 0; m_c1 = 0; m_rv = 0; m_rd = '0; m_rf = 8'h00;
        end else begin
            acc  = op_valid && (!m_rv || rsp_ready);
            m_rv = acc || (m_rv && !rsp_ready);
            stk  = 0;
            ovf  = 0;
            if (acc) begin
                p    = (m_top + int'(op_idx)) % D;
                nt   = (m_top + D - 1) % D;
                m_rd = '0;
                m_rf = 8'h00;
                case (op_code)
                    PUSH: if (m_tag[nt]) begin
                        m_rf = 8'h11; stk = 1; ovf = 1;
                        if (MASKED) begin m_mem[nt] = '1; m_top = nt; end
                    end else begin
                        m_mem[nt] = op_wdata; m_tag[nt] = 1; m_top = nt;
                    end
                    POP: if (!m_tag[m_top]) begin
                        m_rf = 8'h10; stk = 1;
                        if (MASKED) begin m_rd = '1; m_top = (m_top + 1) % D; end
                    end else begin
                        m_rd = m_mem[m_top]; m_tag[m_top] = 0; m_top = (m_top + 1) % D;
                    end
                    READ: if (m_tag[p]) m_rd = m_mem[p];
                          else begin m_rf = 8'h10; stk = 1; if (MASKED) m_rd = '1; end
                    WRITE: begin m_mem[p] = op_wdata; m_tag[p] = 1; end
                    EXCH: if (m_tag[m_top] && m_tag[p]) begin
                        m_rd = m_mem[m_top]; tmp = m_mem[p];
                        m_mem[p] = m_mem[m_top]; m_mem[m_top] = tmp;
                    end else begin m_rf = 8'h10; stk = 1; end
                    FREE: m_tag[p] = 0;
                    ILL: m_rf = 8'h12;
                    default: ;
                endcase
            end
            if (stk) begin m_ie = 1; m_c1 = ovf; end
            else if (sw_clr) begin m_ie = 0; m_c1 = 0; end
        end
    end

    always @(negedge clk) begin
        chk("top", 80'(top), 80'(m_top));
        chk("tag", 80'(tag), 80'(m_tagv()));
        chk("sw", 80'(sw), 80'(m_sw()));
        chk("op_ready", 80'(op_ready), 80'(!m_rv || rsp_ready));
        chk("rsp_valid", 80'(rsp_valid), 80'(m_rv));
        if (m_rv) begin
            chk("rsp_data", rsp_data, m_rd);
            chk("rsp_fault", 80'(rsp_fault), 80'(m_rf));
        end
    end

    task automatic do_op(input logic [2:0] c, input logic [2:0] i, input logic [79:0] d);
        op_valid = 1; op_code = c; op_idx = i; op_wdata = d;
        @(posedge clk); #1;
        op_valid = 0;
    endtask

    task automatic rst_pulse();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic lit(input string n, input logic [79:0] rd, input logic [7:0] rf,
                       input logic [15:0] s, input logic [2:0] t, input logic [7:0] g);
        chk({n, "_data"}, rsp_data, rd);
        chk({n, "_fault"}, 80'(rsp_fault), 80'(rf));
        chk({n, "_sw"}, 80'(sw), 80'(s));
        chk({n, "_top"}, 80'(top), 80'(t));
        chk({n, "_tag"}, 80'(tag), 80'(g));
    endtask

    initial begin
        int a0;
        rst = 0; op_valid = 0; op_code = 0; op_idx = 0; op_wdata = 0; rsp_ready = 1; sw_clr = 0;
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_valid", 80'(rsp_valid), 80'(0));
        lit("reset", 80'h0, 8'h00, 16'h0000, 3'd0, 8'h00);
        do_op(PUSH, 0, 80'h1);
        lit("push1", 80'h0, 8'h00, 16'h3800, 3'd7, 8'h80);
        for (int v = 2; v <= 8; v++) do_op(PUSH, 0, 80'(v));
        lit("full", 80'h0, 8'h00, 16'h0000, 3'd0, 8'hFF);
        do_op(PUSH, 0, 80'h9);
        lit("ovf", 80'h0, 8'h11, 16'h02C1, 3'd0, 8'hFF);
        rst_pulse();
        chk("rst_discard", 80'(rsp_valid), 80'(0));
        do_op(POP, 0, 80'h0);
        lit("unf", 80'h0, 8'h10, 16'h00C1, 3'd0, 8'h00);
        sw_clr = 1;
        @(posedge clk); #1;
        sw_clr = 0;
        chk("sw_clr", 80'(sw), 80'h0);
        do_op(PUSH, 0, 80'h5);
        do_op(PUSH, 0, 80'h9);
        do_op(READ, 1, 80'h0);
        chk("read1", rsp_data, 80'h5);
        do_op(EXCH, 1, 80'h0);
        chk("exch1", rsp_data, 80'h9);
        do_op(READ, 0, 80'h0);
        chk("read0", rsp_data, 80'h5);
        do_op(POP, 0, 80'h0);
        chk("pop_a", rsp_data, 80'h5);
        do_op(POP, 0, 80'h0);
        lit("pop_b", 80'h9, 8'h00, 16'h0000, 3'd0, 8'h00);
        @(posedge clk); #1;
        rsp_ready = 0; op_valid = 1; op_code = PUSH; op_idx = 0; op_wdata = 80'h77;
        a0 = d_acc;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_ready", 80'(op_ready), 80'(0));
        end
        chk("stall_acc", 80'(d_acc - a0), 80'(1));
        chk("stall_data", rsp_data, 80'h0);
        rsp_ready = 1;
        #1 chk("resume_ready", 80'(op_ready), 80'(1));
        @(posedge clk); #1;
        op_valid = 0;
        chk("resume_acc", 80'(d_acc - a0), 80'(2));
        chk("resume_tag", 80'(tag), 80'hC0);
        do_op(ILL, 0, 80'h0);
        lit("ill", 80'h0, 8'h12, 16'h3000, 3'd6, 8'hC0);
        rst_pulse();
        sw_clr = 1;
        do_op(POP, 0, 80'h0);
        sw_clr = 0;
        lit("clr_unf", 80'h0, 8'h10, 16'h00C1, 3'd0, 8'h00);
        do_op(WRITE, 3, 80'hAB);
        chk("write_tag", 80'(tag), 80'h08);
        do_op(READ, 3, 80'h0);
        chk("read3", rsp_data, 80'hAB);
        do_op(EXCH, 0, 80'h0);
        chk("exch_empty", 80'(rsp_fault), 80'h10);
        do_op(FREE, 3, 80'h0);
        chk("free_tag", 80'(tag), 80'h00);
        do_op(READ, 3, 80'h0);
        chk("read_free", 80'(rsp_fault), 80'h10);
        do_op(NOP, 0, 80'h3);
        lit("nop", 80'h0, 8'h00, 16'h00C1, 3'd0, 8'h00);
        do_op(PUSH, 0, 80'h42);
        do_op(WRITE, 1, 80'h55);
        chk("wrap_tag", 80'(tag), 80'h81);
        do_op(EXCH, 1, 80'h0);
        chk("exch_wrap", rsp_data, 80'h42);
        do_op(READ, 0, 80'h0);
        chk("read_wrap0", rsp_data, 80'h55);
        do_op(READ, 1, 80'h0);
        chk("read_wrap1", rsp_data, 80'h42);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
